// File: rtl/char_num_conv.sv
// Iterative converter between binary words and MIX decimal character strings.
// The converter processes one digit per clock in either direction behind a start/done handshake.
module char_num_conv #(
    parameter int unsigned WORD_W = 30,
    parameter int unsigned NDIG   = 10,
    parameter int unsigned CHAR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [WORD_W-1:0]        in_bin,
    input  logic [NDIG*CHAR_W-1:0]   in_chars,
    output logic                     busy,
    output logic                     done,
    output logic [NDIG*CHAR_W-1:0]   out_chars,
    output logic [WORD_W-1:0]        out_bin,
    output logic                     ovf
);

    localparam int unsigned TOT_W = NDIG * CHAR_W;
    localparam int unsigned EXT_W = WORD_W + 4;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic [WORD_W-1:0]   w_q, w_d;
    logic [TOT_W-1:0]    src_q, src_d;
    logic [TOT_W-1:0]    out_chars_q, out_chars_d;
    logic [WORD_W-1:0]   out_bin_q, out_bin_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   quo_c;
    logic [3:0]          rem_c;
    logic [CHAR_W-1:0]   code_c;
    logic [CHAR_W-1:0]   top_chr_c;
    logic [3:0]          dig_c;
    logic [EXT_W-1:0]    acc_full_c;
    logic                accept_c;
    logic                last_c;

    // Next-state and datapath: divide-by-10 for CHAR, multiply-accumulate for NUM.
    always_comb begin
        quo_c      = w_q / WORD_W'(10);
        rem_c      = 4'(w_q % WORD_W'(10));
        code_c     = CHAR_W'(30) + CHAR_W'(rem_c);
        top_chr_c  = src_q[TOT_W-1 -: CHAR_W];
        dig_c      = 4'(top_chr_c % CHAR_W'(10));
        acc_full_c = EXT_W'(out_bin_q) * EXT_W'(10) + EXT_W'(dig_c);
        accept_c   = start && (state_q != S_RUN);
        last_c     = (cnt_q == CNT_W'(NDIG - 1));

        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        w_d         = w_q;
        src_d       = src_q;
        out_chars_d = out_chars_q;
        out_bin_d   = out_bin_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                if (!mode_q) begin
                    w_d         = quo_c;
                    out_chars_d = (out_chars_q >> CHAR_W)
                                | (TOT_W'(code_c) << (TOT_W - CHAR_W));
                    if (last_c) begin
                        ovf_d = (quo_c != '0);
                    end
                end else begin
                    out_bin_d = acc_full_c[WORD_W-1:0];
                    src_d     = src_q << CHAR_W;
                    if (acc_full_c[EXT_W-1:WORD_W] != 4'd0) begin
                        ovf_d = 1'b1;
                    end
                end
                if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A start in DONE restarts immediately; the done pulse is already registered.
        if (accept_c) begin
            state_d = S_RUN;
            cnt_d   = '0;
            mode_d  = mode;
            ovf_d   = 1'b0;
            if (!mode) begin
                w_d = in_bin;
            end else begin
                src_d     = in_chars;
                out_bin_d = '0;
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            w_q         <= '0;
            src_q       <= '0;
            out_chars_q <= '0;
            out_bin_q   <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            w_q         <= w_d;
            src_q       <= src_d;
            out_chars_q <= out_chars_d;
            out_bin_q   <= out_bin_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_chars = out_chars_q;
    assign out_bin   = out_bin_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_char_num_conv.sv
// Directed table-driven bench for char_num_conv (default and NDIG=4 instances).
module tb_char_num_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [29:0] in_bin;
    logic [59:0] in_chars;
    logic        busy;
    logic        done;
    logic [59:0] out_chars;
    logic [29:0] out_bin;
    logic        ovf;

    logic        start4;
    logic [23:0] in_chars4;
    logic        busy4;
    logic        done4;
    logic [23:0] out_chars4;
    logic [29:0] out_bin4;
    logic        ovf4;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        m;
        logic [29:0] bin;
        logic [59:0] chars;
        logic [59:0] exp_chars;
        logic [29:0] exp_bin;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t vecs[10];

    char_num_conv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .in_bin(in_bin), .in_chars(in_chars), .busy(busy), .done(done),
        .out_chars(out_chars), .out_bin(out_bin), .ovf(ovf)
    );

    char_num_conv #(.WORD_W(30), .NDIG(4), .CHAR_W(6)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode),
        .in_bin(in_bin), .in_chars(in_chars4), .busy(busy4), .done(done4),
        .out_chars(out_chars4), .out_bin(out_bin4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Issue a start for one cycle, then wait (bounded) for done; lat counts negedges after E0.
    task automatic run_conv(input logic m, input logic [29:0] b, input logic [59:0] c,
                            output int lat);
        @(negedge clk);
        mode = m; in_bin = b; in_chars = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [59:0] first_chars;
        logic [59:0] hold_chars;

        vecs[0] = '{1'b0, 30'd12977, 60'd0,
                    {6'd30,6'd30,6'd30,6'd30,6'd30,6'd31,6'd32,6'd39,6'd37,6'd37},
                    30'd0, 1'b0, "char_12977"};
        vecs[1] = '{1'b0, 30'd1073741823, 60'd0,
                    {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33},
                    30'd0, 1'b0, "char_max"};
        vecs[2] = '{1'b0, 30'd0, 60'd0, {10{6'd30}}, 30'd0, 1'b0, "char_zero"};
        vecs[3] = '{1'b0, 30'd1000000000, 60'd0, {6'd31, {9{6'd30}}},
                    30'd0, 1'b0, "char_1e9"};
        vecs[4] = '{1'b1, 30'd0,
                    {6'd0,6'd0,6'd31,6'd32,6'd0,6'd39,6'd30,6'd37,6'd37,6'd9},
                    60'd0, 30'd12090779, 1'b0, "num_mixed"};
        vecs[5] = '{1'b1, 30'd0, {10{6'd39}}, 60'd0, 30'd336323583, 1'b1, "num_all9"};
        vecs[6] = '{1'b1, 30'd0,
                    {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33},
                    60'd0, 30'd1073741823, 1'b0, "num_max"};
        vecs[7] = '{1'b1, 30'd0,
                    {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd34},
                    60'd0, 30'd0, 1'b1, "num_max_plus1"};
        vecs[8] = '{1'b1, 30'd0, {{7{6'd0}}, 6'd15, 6'd45, 6'd63},
                    60'd0, 30'd553, 1'b0, "num_odd_codes"};
        vecs[9] = '{1'b0, 30'd9, 60'd0, {{9{6'd30}}, 6'd39}, 30'd0, 1'b0, "char_9"};

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; mode = 1'b0;
        in_bin = '0; in_chars = '0; in_chars4 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_out_chars", 64'(out_chars), 64'd0);
        check("reset_out_bin", 64'(out_bin), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].m, vecs[i].bin, vecs[i].chars, lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd11);
            if (vecs[i].m)
                check({vecs[i].name, "_out_bin"}, 64'(out_bin), 64'(vecs[i].exp_bin));
            else
                check({vecs[i].name, "_out_chars"}, 64'(out_chars), 64'(vecs[i].exp_chars));
            check({vecs[i].name, "_ovf"}, 64'(ovf), 64'(vecs[i].exp_ovf));
            check({vecs[i].name, "_busy_at_done"}, 64'(busy), 64'd0);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
        end

        // Start during RUN must be ignored.
        @(negedge clk);
        mode = 1'b0; in_bin = 30'd12977; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_after_e0", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        mode = 1'b1; in_bin = 30'd5; in_chars = {10{6'd39}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_chars = '0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                if (ndone == 0) first_chars = out_chars;
                ndone++;
            end
            @(negedge clk);
        end
        check("ign_done_count", 64'(ndone), 64'd1);
        check("ign_result", 64'(first_chars), 64'(vecs[0].exp_chars));

        // Start held high: one conversion every NDIG+1 clocks.
        mode = 1'b0; in_bin = 30'd111; start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("b2b_first_latency", 64'(lat), 64'd11);
        check("b2b_first_result", 64'(out_chars), 64'({{7{6'd30}}, 6'd31, 6'd31, 6'd31}));
        in_bin = 30'd222;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        start = 1'b0;
        check("b2b_interval", 64'(lat), 64'd11);
        check("b2b_second_result", 64'(out_chars), 64'({{7{6'd30}}, 6'd32, 6'd32, 6'd32}));

        // Asynchronous reset in the middle of a conversion.
        run_conv(1'b1, 30'd0, {{9{6'd30}}, 6'd37}, lat);
        check("pre_rst_out_bin", 64'(out_bin), 64'd7);
        @(negedge clk);
        mode = 1'b0; in_bin = 30'd1073741823; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_ovf", 64'(ovf), 64'd0);
        check("rst_mid_out_chars", 64'(out_chars), 64'd0);
        check("rst_mid_out_bin", 64'(out_bin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_no_done", 64'(ndone), 64'd0);
        run_conv(1'b0, 30'd12977, 60'd0, lat);
        check("rst_recover_latency", 64'(lat), 64'd11);
        check("rst_recover_result", 64'(out_chars), 64'(vecs[0].exp_chars));

        // Mode isolation: out_chars must hold through a NUM conversion.
        hold_chars = vecs[0].exp_chars;
        @(negedge clk);
        mode = 1'b1; in_chars = {10{6'd39}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            check("iso_out_chars_run", 64'(out_chars), 64'(hold_chars));
            @(negedge clk);
            lat++;
        end
        check("iso_latency", 64'(lat), 64'd11);
        check("iso_out_chars_done", 64'(out_chars), 64'(hold_chars));
        check("iso_out_bin", 64'(out_bin), 64'd336323583);

        // NDIG=4 instance: leading digits discarded and flagged.
        @(negedge clk);
        mode = 1'b0; in_bin = 30'd1073741823; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin @(negedge clk); lat++; end
        check("n4_max_latency", 64'(lat), 64'd5);
        check("n4_max_out_chars", 64'(out_chars4), 64'({6'd31, 6'd38, 6'd32, 6'd33}));
        check("n4_max_ovf", 64'(ovf4), 64'd1);
        @(negedge clk);
        in_bin = 30'd1823; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin @(negedge clk); lat++; end
        check("n4_fit_latency", 64'(lat), 64'd5);
        check("n4_fit_out_chars", 64'(out_chars4), 64'({6'd31, 6'd38, 6'd32, 6'd33}));
        check("n4_fit_ovf", 64'(ovf4), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
